// File: rtl/line_window_reader_if.sv
// Pixel-stream / window bus for line_window_reader.
//   master : pixel source side (drives pix_valid, sof, pix_in, tap0, tap1;
//            observes shift and the window outputs)
//   slave  : line_window_reader itself
// Signals:
//   pix_valid, sof, pix_in : live pixel stream (row y)
//   tap0, tap1             : line buffer outputs (rows y-1, y-2), same column
//   shift                  : shift strobe to both line buffers
//   win_valid, win         : registered 3x3 window, pixel (r,c) at win[8*(3r+c)+:8]
//   win_row, win_col       : centre coordinates of win
//   frame_done, sof_err    : one-cycle status pulses
interface line_window_reader_if #(
  parameter int COL_W = 9,
  parameter int ROW_W = 8
);
  logic             pix_valid;
  logic             sof;
  logic [7:0]       pix_in;
  logic [7:0]       tap0;
  logic [7:0]       tap1;
  logic             shift;
  logic             win_valid;
  logic [71:0]      win;
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;
  logic             frame_done;
  logic             sof_err;

  modport master (
    output pix_valid, sof, pix_in, tap0, tap1,
    input  shift, win_valid, win, win_row, win_col, frame_done, sof_err
  );

  modport slave (
    input  pix_valid, sof, pix_in, tap0, tap1,
    output shift, win_valid, win, win_row, win_col, frame_done, sof_err
  );
endinterface

// File: rtl/line_window_reader.sv
// Read side of the two-deep line-buffer chain. Accepts the live pixel
// stream, strobes the line buffers, and assembles a registered 3x3
// neighbourhood window with its centre coordinates.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : line_window_reader_if.slave (stream in, window out)
module line_window_reader #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int COL_W      = 9,
  parameter int ROW_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  line_window_reader_if.slave   bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [71:0]      sr_q, sr_d;
  logic [71:0]      win_q, win_d;
  logic [ROW_W-1:0] win_row_q, win_row_d;
  logic [COL_W-1:0] win_col_q, win_col_d;
  logic             win_valid_q, win_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             sof_err_q, sof_err_d;

  logic             accept;
  logic             last_px;
  logic             restart;
  logic [ROW_W-1:0] pos_row;
  logic [COL_W-1:0] pos_col;
  logic             emit;

  always_comb begin
    accept  = bus.pix_valid & ((state_q != IDLE) | bus.sof);
    // The final pixel of a frame takes priority over a coincident sof.
    last_px = (state_q == RUN) & (row_q == ROW_LAST) & (col_q == COL_LAST);
    restart = bus.sof & ~last_px;
    // Position of the pixel being accepted; sof forces it to (0,0).
    pos_row = restart ? '0 : row_q;
    pos_col = restart ? '0 : col_q;
    emit    = accept & (pos_row >= ROW_W'(2)) & (pos_col >= COL_W'(2));
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    sr_d         = sr_q;
    win_d        = win_q;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    sof_err_d    = 1'b0;

    if (accept) begin
      // Shift window columns left; the new right column is {tap1, tap0, pix_in}
      // from top row to bottom row.
      for (int r = 0; r < 3; r++) begin
        sr_d[8*(3*r)   +: 8] = sr_q[8*(3*r+1) +: 8];
        sr_d[8*(3*r+1) +: 8] = sr_q[8*(3*r+2) +: 8];
      end
      sr_d[8*2 +: 8] = bus.tap1;
      sr_d[8*5 +: 8] = bus.tap0;
      sr_d[8*8 +: 8] = bus.pix_in;

      if (last_px) begin
        state_d      = IDLE;
        row_d        = '0;
        col_d        = '0;
        frame_done_d = 1'b1;
      end else begin
        state_d   = RUN;
        sof_err_d = bus.sof & (state_q == RUN);
        if (pos_col == COL_LAST) begin
          col_d = '0;
          row_d = pos_row + ROW_W'(1);
        end else begin
          col_d = pos_col + COL_W'(1);
          row_d = pos_row;
        end
      end

      // Output window only loads on a complete window, so win and the
      // coordinates hold while win_valid is low.
      if (emit) begin
        win_valid_d = 1'b1;
        win_d       = sr_d;
        win_row_d   = pos_row - ROW_W'(1);
        win_col_d   = pos_col - COL_W'(1);
      end
    end
  end

  // Stage boundary: accepted pixel -> registered window and status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      sr_q         <= '0;
      win_q        <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      sr_q         <= sr_d;
      win_q        <= win_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      sof_err_q    <= sof_err_d;
    end
  end

  assign bus.shift      = accept;
  assign bus.win_valid  = win_valid_q;
  assign bus.win        = win_q;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sof_err    = sof_err_q;

endmodule

// File: doc/line_window_reader.md
Name: line_window_reader

Overview:
- Consumer (read) side of the pixel line-buffer chain.
- Accepts the live pixel stream and drives the shift strobe of two cascaded line buffers, each IMG_WIDTH deep.
- Combines the live pixel with both buffer outputs into a registered 3x3 neighbourhood window, plus the window-centre coordinates.
- Sits between the camera pixel stream and the downstream stereo/filter kernels.

Parameters:
- IMG_WIDTH, 320, pixels per line; must equal the line-buffer NUM_REGS; minimum 3.
- IMG_HEIGHT, 240, lines per frame; minimum 3.
- COL_W, 9, column counter / coordinate width; must satisfy 2^COL_W > IMG_WIDTH.
- ROW_W, 8, row counter / coordinate width; must satisfy 2^ROW_W > IMG_HEIGHT.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- pix_valid  in  1  pix_in is valid this cycle.
- sof  in  1  start of frame; qualified by pix_valid; marks pixel (0,0).
- pix_in  in  8  live pixel, row y.
- tap0  in  8  output of line buffer 1, row y-1; same column as pix_in.
- tap1  in  8  output of line buffer 2, row y-2; same column as pix_in.
- shift  out  1  shift strobe to both line buffers (combinational).
- win_valid  out  1  win/win_row/win_col hold a complete window.
- win  out  72  3x3 window; pixel (r,c) is at win[8*(3r+c)+:8].
  - r=0 is the top row (y-2); c=0 is the left column (oldest).
  - Centre pixel is win[39:32].
- win_row  out  ROW_W  row of the centre pixel.
- win_col  out  COL_W  column of the centre pixel.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame.
- sof_err  out  1  one-cycle pulse when sof arrives mid-frame.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; row and column counters = 0.
  - Window registers, win, win_valid, win_row, win_col, frame_done, sof_err all 0.
- accept = pix_valid & (state!=IDLE | sof).
- shift = accept, combinational. Line buffers update on the same edge, so tap0/tap1 are sampled before they shift.
- States:
  - IDLE: wait for accept with sof → RUN, pixel treated as (0,0).
  - RUN: each accepted pixel advances col. At col==IMG_WIDTH-1, col wraps to 0 and row increments.
  - Accepting (IMG_HEIGHT-1, IMG_WIDTH-1) → IDLE, frame_done=1 on the next cycle.
- IDLE with pix_valid and no sof: pixel dropped, shift=0, no output change.
- On accept, window columns shift left: column 0 ← column 1 ← column 2 ← {tap1, tap0, pix_in} (top to bottom).
- Centre coordinates: the incoming pixel at (row,col) completes the window centred at (row-1, col-1).
- win_valid, registered:
  - 1 on the cycle after an accept with row≥2 and col≥2; 0 otherwise, including cycles with no accept.
  - Latency is 1 clock from accept to window.
  - win_row = row-1 and win_col = col-1 are registered with win.
- win and coordinates hold their last value when win_valid=0.
- Windows straddling a line wrap hold stale columns; col≥2 gating suppresses them.
- Each frame produces exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows, in raster order.
- sof in RUN:
  - Counters restart; the pixel is (0,0); sof_err pulses next cycle.
  - No window is emitted for that pixel; state stays RUN.
- sof on the final pixel of a frame: the final-pixel rule wins; frame_done pulses and sof_err stays 0.
- pix_valid gaps (any length): no state change, shift=0, outputs hold.
- Reset asserted mid-frame: immediate return to reset values. Line-buffer contents are stale but are never emitted, because row<2 gating applies until two fresh lines are in.

Test Plan:
- W=4,H=4, pixel value = 16*row+col, continuous pix_valid, sof on first pixel:
  - exactly 4 win_valid pulses, at (1,1),(1,2),(2,1),(2,2);
  - window at (1,1) = {00,01,02,10,11,12,20,21,22};
  - frame_done 1 cycle after pixel (3,3).
- Same frame with random 0–3 cycle pix_valid gaps: identical window sequence; shift pulse count = 16; win_valid never asserted during gaps.
- 5 pixels with pix_valid=1 and sof=0 after reset: shift stays 0, no outputs. Then sof: normal frame.
- sof reasserted at pixel (2,1): sof_err pulses once; counters restart; next window is at (1,1) of the new frame.
- reset_n pulled low mid-row 2: all outputs 0 asynchronously. After release plus sof, the first window is at (1,1) with correct, non-stale pixels.
- Two back-to-back frames with sof immediately after the last pixel: 8 windows total, 2 frame_done pulses, sof_err never asserted.
